// File: rtl/quantize_pipe.sv
// Multi-lane two-stage requantizer: shift + round (S1), saturate to OUT_DW (S2), sticky saturation counter.
// Optional build macro QUANT_RELU_EN adds a per-beat relu_en input that zeroes negative results.
module quantize_pipe #(
   parameter int LANES   = 4,
   parameter int IN_DW   = 19,
   parameter int OUT_DW  = 8,
   parameter int SHIFT_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*IN_DW-1:0]    in_data,
   input  logic [SHIFT_W-1:0]        in_shift,
   input  logic [1:0]                in_rmode,
`ifdef QUANT_RELU_EN
   input  logic                      relu_en,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*OUT_DW-1:0]   out_data,
   output logic [LANES-1:0]          out_sat,
   output logic [CNT_W-1:0]          sat_cnt,
   input  logic                      sat_clr
);

   localparam int RW = IN_DW + 1;
   localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (OUT_DW - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic signed [RW-1:0] round_lane(input logic signed [IN_DW-1:0] x,
                                                       input logic [SHIFT_W-1:0]     s,
                                                       input logic [1:0]             mode);
      logic signed [RW-1:0] r;
      logic                 half;
      logic                 rest;
      logic                 carry;
      r    = {x[IN_DW-1], x};
      r    = r >>> s;
      half = 1'b0;
      rest = 1'b0;
      // half is the first dropped bit, rest ORs everything below it; both stay 0 for s=0
      for (int b = 0; b < IN_DW; b++) begin
         if (b == int'(s) - 1) half = x[b];
         if (b < int'(s) - 1)  rest = rest | x[b];
      end
      case (mode)
         2'd0:    carry = 1'b0;
         2'd2:    carry = half;
         default: carry = half & (~x[IN_DW-1] | rest);
      endcase
      return r + RW'(carry);
   endfunction

   // Returns {sat_flag, clamped value}
   function automatic logic [OUT_DW:0] saturate(input logic signed [RW-1:0] r,
                                                input logic                 relu);
      if (relu && r < 0)  return '0;
      if (r > SAT_MAX)    return {1'b1, SAT_MAX[OUT_DW-1:0]};
      if (r < SAT_MIN)    return {1'b1, SAT_MIN[OUT_DW-1:0]};
      return {1'b0, r[OUT_DW-1:0]};
   endfunction

   function automatic logic [CNT_W:0] popcount(input logic [LANES-1:0] v);
      logic [CNT_W:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) c = c + (CNT_W+1)'(v[i]);
      return c;
   endfunction

   logic                      relu_in;
   logic                      vld_p1_q;
   logic signed [RW-1:0]      r_p1_q [LANES];
   logic signed [RW-1:0]      r_p1_d [LANES];
   logic                      relu_p1_q;
   logic                      vld_p2_q;
   logic [LANES*OUT_DW-1:0]   out_data_p2_q;
   logic [LANES*OUT_DW-1:0]   out_data_p2_d;
   logic [LANES-1:0]          out_sat_p2_q;
   logic [LANES-1:0]          out_sat_p2_d;
   logic [CNT_W-1:0]          sat_cnt_q;
   logic [CNT_W-1:0]          sat_cnt_d;
   logic [CNT_W:0]            cnt_sum;
   logic                      s2_adv;
   logic                      accept;

`ifdef QUANT_RELU_EN
   assign relu_in = relu_en;
`else
   assign relu_in = 1'b0;
`endif

   assign s2_adv   = ~vld_p2_q | out_ready;
   assign in_ready = ~vld_p1_q | s2_adv;
   assign accept   = in_valid & in_ready;

   always_comb begin
      logic [OUT_DW:0] sq;
      sq            = '0;
      out_data_p2_d = '0;
      out_sat_p2_d  = '0;
      for (int i = 0; i < LANES; i++) begin
         r_p1_d[i] = round_lane(in_data[i*IN_DW +: IN_DW], in_shift, in_rmode);
         sq        = saturate(r_p1_q[i], relu_p1_q);
         out_sat_p2_d[i]                   = sq[OUT_DW];
         out_data_p2_d[i*OUT_DW +: OUT_DW] = sq[OUT_DW-1:0];
      end
   end

   // A clear in the same cycle as an increment wins
   always_comb begin
      cnt_sum   = {1'b0, sat_cnt_q} + popcount(out_sat_p2_q);
      sat_cnt_d = sat_cnt_q;
      if (sat_clr)
         sat_cnt_d = '0;
      else if (vld_p2_q && out_ready)
         sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   // ---- S1: rounded lanes, captured with their beat ----
   always_ff @(posedge clk) begin
      if (accept) begin
         r_p1_q    <= r_p1_d;
         relu_p1_q <= relu_in;
      end
   end

   // ---- S2: saturated output register, control and counter ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q      <= 1'b0;
         vld_p2_q      <= 1'b0;
         out_data_p2_q <= '0;
         out_sat_p2_q  <= '0;
         sat_cnt_q     <= '0;
      end else begin
         if (in_ready) vld_p1_q <= in_valid;
         if (s2_adv) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
               out_data_p2_q <= out_data_p2_d;
               out_sat_p2_q  <= out_sat_p2_d;
            end
         end
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign out_valid = vld_p2_q;
   assign out_data  = out_data_p2_q;
   assign out_sat   = out_sat_p2_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_quantize_pipe.sv
// Self-checking bench for quantize_pipe: directed cases plus a randomized backpressure stream vs. an arithmetic model.
module tb_quantize_pipe;
   localparam int LANES = 4, IN_DW = 19, OUT_DW = 8, SHIFT_W = 3, CNT_W = 16;
   localparam int QMAX = 127, QMIN = -128;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*IN_DW-1:0]  in_data;
   logic [SHIFT_W-1:0]      in_shift;
   logic [1:0]              in_rmode;
`ifdef QUANT_RELU_EN
   logic                    relu_en;
`endif
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*OUT_DW-1:0] out_data;
   logic [LANES-1:0]        out_sat;
   logic [CNT_W-1:0]        sat_cnt;
   logic                    sat_clr;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   quantize_pipe #(.LANES(LANES), .IN_DW(IN_DW), .OUT_DW(OUT_DW), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shift(in_shift), .in_rmode(in_rmode),
`ifdef QUANT_RELU_EN
      .relu_en(relu_en),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .sat_cnt(sat_cnt), .sat_clr(sat_clr));

   function automatic logic [LANES*IN_DW-1:0] pack_in(input int a, input int b, input int c, input int d);
      logic [LANES*IN_DW-1:0] v;
      v[0*IN_DW +: IN_DW] = IN_DW'(a);
      v[1*IN_DW +: IN_DW] = IN_DW'(b);
      v[2*IN_DW +: IN_DW] = IN_DW'(c);
      v[3*IN_DW +: IN_DW] = IN_DW'(d);
      return v;
   endfunction

   function automatic logic [LANES*OUT_DW-1:0] pack_out(input int a, input int b, input int c, input int d);
      logic [LANES*OUT_DW-1:0] v;
      v[0*OUT_DW +: OUT_DW] = OUT_DW'(a);
      v[1*OUT_DW +: OUT_DW] = OUT_DW'(b);
      v[2*OUT_DW +: OUT_DW] = OUT_DW'(c);
      v[3*OUT_DW +: OUT_DW] = OUT_DW'(d);
      return v;
   endfunction

   function automatic longint floor_div(input longint a, input longint d);
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   // Reference: x / 2^s rounded per mode, then clamped (or zeroed when relu and negative)
   function automatic int model_lane(input int x, input int s, input int m, input bit relu, output bit sat);
      longint p, h, q, xl;
      xl  = x;
      sat = 1'b0;
      if (s == 0) q = xl;
      else begin
         p = longint'(1) << s;
         h = p / 2;
         if (m == 0)      q = floor_div(xl, p);
         else if (m == 2) q = floor_div(xl + h, p);
         else             q = (xl >= 0) ? (xl + h) / p : -((-xl + h) / p);
      end
      if (relu && q < 0) return 0;
      if (q > QMAX) begin sat = 1'b1; return QMAX; end
      if (q < QMIN) begin sat = 1'b1; return QMIN; end
      return int'(q);
   endfunction

   function automatic int rand_x();
      case ($urandom_range(0, 2))
         0:       return int'($urandom_range(0, 600)) - 300;
         1:       return int'($urandom_range(0, 6000)) - 3000;
         default: return int'($urandom_range(0, (1 << IN_DW) - 1)) - (1 << (IN_DW - 1));
      endcase
   endfunction

   task automatic send_and_get(input logic [LANES*IN_DW-1:0] d, input int sh, input int rm, input bit re,
                               output logic [LANES*OUT_DW-1:0] od, output logic [LANES-1:0] os,
                               output bit ok, output int lat);
      @(posedge clk); #1;
      in_data  = d;
      in_shift = SHIFT_W'(sh);
      in_rmode = 2'(rm);
`ifdef QUANT_RELU_EN
      relu_en  = re;
`endif
      in_valid = 1'b1;
      ok = 1'b0; lat = 0; od = '0; os = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) return;
      ok = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; lat = i; od = out_data; os = out_sat; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
      in_data = '0; in_shift = '0; in_rmode = '0;
`ifdef QUANT_RELU_EN
      relu_en = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL reset_sat_cnt got=%h exp=0", sat_cnt); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (out_sat !== '0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
      exp_cnt = 0;
   endtask

   task automatic test_rounding();
      logic [LANES*OUT_DW-1:0] od, ed;
      logic [LANES-1:0] os;
      bit ok; int lat, m;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin m = 1; ed = pack_out(3, -3, 2, -2); end
            1:       begin m = 0; ed = pack_out(2, -3, 1, -2); end
            default: begin m = 2; ed = pack_out(3, -2, 2, -1); end
         endcase
         send_and_get(pack_in(20, -20, 12, -12), 3, m, 1'b0, od, os, ok, lat);
         checks++; if (!ok) begin errors++; $display("FAIL round_m%0d_timeout got=none exp=beat", m); end
         checks++; if (lat != 2) begin errors++; $display("FAIL round_m%0d_latency got=%0d exp=2", m, lat); end
         checks++; if (od !== ed) begin errors++; $display("FAIL round_m%0d_data got=%h exp=%h", m, od, ed); end
         checks++; if (os !== 4'b0000) begin errors++; $display("FAIL round_m%0d_sat got=%b exp=0000", m, os); end
      end
   endtask

   task automatic test_saturation();
      logic [LANES*OUT_DW-1:0] od, ed;
      logic [LANES-1:0] os;
      bit ok; int lat;
      ed = pack_out(127, -128, 127, -128);
      send_and_get(pack_in(2000, -2000, 1016, -1024), 3, 1, 1'b0, od, os, ok, lat);
      exp_cnt += 2;
      checks++; if (!ok || od !== ed) begin errors++; $display("FAIL sat_data got=%h exp=%h", od, ed); end
      checks++; if (os !== 4'b0011) begin errors++; $display("FAIL sat_flags got=%b exp=0011", os); end
      @(posedge clk); #1;
      checks++; if (sat_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_cnt_inc got=%0d exp=%0d", sat_cnt, exp_cnt); end
   endtask

   task automatic test_shift_edges();
      logic [LANES*OUT_DW-1:0] od, ed;
      logic [LANES-1:0] os;
      bit ok; int lat;
      ed = pack_out(100, -100, 127, -128);
      send_and_get(pack_in(100, -100, 200, -200), 0, 1, 1'b0, od, os, ok, lat);
      exp_cnt += 2;
      checks++; if (!ok || od !== ed) begin errors++; $display("FAIL shift0_data got=%h exp=%h", od, ed); end
      checks++; if (os !== 4'b1100) begin errors++; $display("FAIL shift0_sat got=%b exp=1100", os); end
      ed = pack_out(1, -1, 0, 0);
      send_and_get(pack_in(64, -64, 0, 0), 7, 1, 1'b0, od, os, ok, lat);
      checks++; if (!ok || od !== ed) begin errors++; $display("FAIL shift7_m1 got=%h exp=%h", od, ed); end
      ed = pack_out(0, -1, 0, 0);
      send_and_get(pack_in(64, -64, 0, 0), 7, 0, 1'b0, od, os, ok, lat);
      checks++; if (!ok || od !== ed) begin errors++; $display("FAIL shift7_m0 got=%h exp=%h", od, ed); end
      @(posedge clk); #1;
      checks++; if (sat_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL shift_sat_cnt got=%0d exp=%0d", sat_cnt, exp_cnt); end
   endtask

   typedef struct { logic [LANES*IN_DW-1:0] d; int sh; int rm; bit re; } beat_t;
   typedef struct { logic [LANES*OUT_DW-1:0] d; logic [LANES-1:0] s; } res_t;

   task automatic test_backpressure();
      beat_t q_in[$];
      res_t  q_exp[$];
      int    rcv;
      beat_t b;
      res_t  e;
      int    x[LANES];
      bit    sat;
      rcv = 0;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < LANES; i++) x[i] = rand_x();
         b.d = pack_in(x[0], x[1], x[2], x[3]);
         b.sh = int'($urandom_range(0, 7));
         b.rm = int'($urandom_range(0, 3));
`ifdef QUANT_RELU_EN
         b.re = 1'($urandom_range(0, 1));
`else
         b.re = 1'b0;
`endif
         for (int i = 0; i < LANES; i++) begin
            e.d[i*OUT_DW +: OUT_DW] = OUT_DW'(model_lane(x[i], b.sh, b.rm, b.re, sat));
            e.s[i] = sat;
            exp_cnt += int'(sat);
         end
         q_in.push_back(b);
         q_exp.push_back(e);
      end
      @(posedge clk); #1;
      fork
         begin : driver
            beat_t cur;
            int guard;
            while (q_in.size() > 0) begin
               cur = q_in.pop_front();
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               in_data = cur.d; in_shift = SHIFT_W'(cur.sh); in_rmode = 2'(cur.rm);
`ifdef QUANT_RELU_EN
               relu_en = cur.re;
`endif
               in_valid = 1'b1;
               guard = 0;
               forever begin
                  @(negedge clk);
                  if (in_ready) begin @(posedge clk); #1; break; end
                  @(posedge clk); #1;
                  guard++;
                  if (guard > 500) break;
               end
            end
            in_valid = 1'b0;
         end
         begin : monitor
            bit stalled;
            logic [LANES*OUT_DW-1:0] held_d;
            logic [LANES-1:0] held_s;
            stalled = 1'b0; held_d = '0; held_s = '0;
            for (int c = 0; c < 3000 && rcv < 20; c++) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
               if (stalled) begin
                  checks++;
                  if (out_valid !== 1'b1 || out_data !== held_d || out_sat !== held_s) begin
                     errors++;
                     $display("FAIL bp_stable got=%b/%h/%b exp=1/%h/%b", out_valid, out_data, out_sat, held_d, held_s);
                  end
               end
               if (out_valid) begin
                  if (out_ready) begin
                     e = q_exp.pop_front();
                     checks++;
                     if (out_data !== e.d || out_sat !== e.s) begin
                        errors++;
                        $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", rcv, out_data, out_sat, e.d, e.s);
                     end
                     rcv++;
                     stalled = 1'b0;
                  end else begin
                     stalled = 1'b1; held_d = out_data; held_s = out_sat;
                  end
               end else stalled = 1'b0;
            end
         end
      join
      out_ready = 1'b1;
      checks++; if (rcv != 20) begin errors++; $display("FAIL bp_count got=%0d exp=20", rcv); end
      repeat (3) @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
      checks++; if (sat_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_sat_cnt got=%0d exp=%0d", sat_cnt, exp_cnt); end
   endtask

   task automatic test_reset_midstream();
      logic [LANES*OUT_DW-1:0] od, ed;
      logic [LANES-1:0] os;
      bit ok; int lat;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_data = pack_in(2000, 0, 0, 0); in_shift = 3'd3; in_rmode = 2'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = pack_in(-2000, 0, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
      checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", sat_cnt); end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      exp_cnt = 0;
      ed = pack_out(5, -5, 0, 0);
      send_and_get(pack_in(40, -40, 0, 0), 3, 0, 1'b0, od, os, ok, lat);
      checks++; if (!ok || lat != 2) begin errors++; $display("FAIL mid_post_latency got=%0d exp=2", lat); end
      checks++; if (od !== ed) begin errors++; $display("FAIL mid_post_data got=%h exp=%h", od, ed); end
      repeat (3) @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b exp=0", out_valid); end
   endtask

   task automatic test_counter_clamp();
      logic [LANES*OUT_DW-1:0] od;
      logic [LANES-1:0] os;
      bit ok; int lat;
      @(posedge clk); #1; sat_clr = 1'b1;
      @(posedge clk); #1; sat_clr = 1'b0;
      exp_cnt = 0;
      checks++; if (sat_cnt !== '0) begin errors++; $display("FAIL clr_alone got=%0d exp=0", sat_cnt); end
      in_data = pack_in(2000, -2000, 2000, -2000); in_shift = 3'd3; in_rmode = 2'd1; in_valid = 1'b1;
      repeat (16383) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      checks++; if (sat_cnt !== 16'd65532) begin errors++; $display("FAIL cnt_near_max got=%0d exp=65532", sat_cnt); end
      for (int k = 0; k < 2; k++) begin
         send_and_get(pack_in(2000, -2000, 2000, -2000), 3, 1, 1'b0, od, os, ok, lat);
         @(posedge clk); #1;
         checks++; if (sat_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_clamp%0d got=%h exp=ffff", k, sat_cnt); end
      end
   endtask

   task automatic test_clear_coincident();
      logic [LANES*OUT_DW-1:0] od;
      logic [LANES-1:0] os;
      bit ok; int lat;
      send_and_get(pack_in(2000, -2000, 2000, -2000), 3, 1, 1'b0, od, os, ok, lat);
      sat_clr = 1'b1;
      @(posedge clk); #1; sat_clr = 1'b0;
      checks++; if (!ok || sat_cnt !== '0) begin errors++; $display("FAIL clr_coincident got=%0d exp=0", sat_cnt); end
      send_and_get(pack_in(0, 5000, -5000, 0), 2, 2, 1'b0, od, os, ok, lat);
      @(posedge clk); #1;
      checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL clr_then_inc got=%0d exp=2", sat_cnt); end
   endtask

`ifdef QUANT_RELU_EN
   task automatic test_relu();
      logic [LANES*OUT_DW-1:0] od, ed;
      logic [LANES-1:0] os;
      bit ok; int lat;
      ed = pack_out(0, 0, 5, 127);
      send_and_get(pack_in(-2000, -5, 40, 2000), 3, 1, 1'b1, od, os, ok, lat);
      checks++; if (!ok || od !== ed) begin errors++; $display("FAIL relu_data got=%h exp=%h", od, ed); end
      checks++; if (os !== 4'b1000) begin errors++; $display("FAIL relu_sat got=%b exp=1000", os); end
      ed = pack_out(-128, -1, 5, 127);
      send_and_get(pack_in(-2000, -5, 40, 2000), 3, 1, 1'b0, od, os, ok, lat);
      checks++; if (!ok || od !== ed || os !== 4'b1001) begin errors++; $display("FAIL relu_off got=%h/%b exp=%h/1001", od, os, ed); end
   endtask
`endif

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_shift_edges();
      test_backpressure();
      test_reset_midstream();
      test_counter_clamp();
      test_clear_coincident();
`ifdef QUANT_RELU_EN
      test_relu();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
